branch_cond_unit: RTL and testbench
===================================

# branch_cond_unit

Registered branch-condition evaluator for the MIPS pipeline, replacing the single-purpose 32-bit equality comparator. It accepts two register operands plus a condition opcode through a valid/ready handshake, resolves the branch one cycle later, and holds the result until the fetch/redirect logic consumes it. It supports the full MIPS conditional-branch set and a pipeline flush. Optional saturating statistics counters can be compiled in.

## Interface
- DATA_W, 32, operand width in bits (≥2)
- CNT_W, 16, width of each statistics counter

- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  kill held result and block acceptance this cycle
- in_valid  in  1  operands and op present
- in_ready  out  1  unit can accept this cycle
- in_op  in  3  condition code (see Operation)
- in_rs  in  DATA_W  first operand
- in_rt  in  DATA_W  second operand (used by BEQ/BNE only)
- out_valid  out  1  resolved result held
- out_ready  in  1  consumer takes result
- out_taken  out  1  branch condition true
- out_neql  out  1  rs != rt, kept for the legacy datapath
- stat_resolved  out  CNT_W  results delivered (0 without macro)
- stat_taken  out  CNT_W  taken results delivered (0 without macro)

## Operation
- Opcodes:
  - 000 BEQ: rs==rt
  - 001 BNE: rs!=rt
  - 010 BLEZ: signed rs≤0
  - 011 BGTZ: signed rs>0
  - 100 BLTZ: rs[DATA_W-1]
  - 101 BGEZ: !rs[DATA_W-1]
  - 110 ALWAYS: 1
  - 111 NEVER: 0
- Signed tests use only the MSB and a zero-detect. No subtraction.
- out_neql = (rs != rt) for every op, captured together with out_taken.
- in_ready = !flush && (!out_valid || out_ready). The output register is single-entry with pass-through on simultaneous drain.
- Accept = in_valid && in_ready. On accept: out_valid←1, and out_taken/out_neql are loaded from the combinational evaluation.
- Output handshake (out_valid && out_ready) without an accept: out_valid←0. Data registers hold their stale values.
- flush=1: out_valid←0 next edge regardless of out_ready, and no accept. The held result is discarded and not counted.
- out_taken/out_neql stay stable while out_valid && !out_ready.

## Timing
- Latency: accept at edge N → out_valid=1 after edge N.
- Sustained throughput is 1 result/cycle when out_ready is held high.
- Reset values (asynchronous, on resetn low):
  - out_valid=0, out_taken=0, out_neql=0
  - counters=0
  - in_ready=1 (combinational) once resetn is high and flush=0
- Reset asserted mid-handshake drops the held result immediately. The first accept is possible on the first edge with resetn high.
- Back-pressure: out_valid=1, out_ready=0 → in_ready=0. in_valid held high is accepted on the cycle out_ready rises.
- Simultaneous flush + in_valid + out_ready: flush wins, nothing accepted, nothing counted.

## Configuration
- BRANCH_COND_STATS_EN defined:
  - stat_resolved increments on every output handshake.
  - stat_taken increments on output handshakes with out_taken=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - Both are reset only by resetn.
- BRANCH_COND_STATS_EN undefined: counters are not built and stat_* are driven to constant 0. The ports remain.

## Structure
- Shared package branch_cond_pkg holds:
  - the 3-bit op enum (BR_BEQ … BR_NEVER)
  - the BR_OP_W=3 constant
- Sub-module branch_cond_eval: purely combinational, parameterised by DATA_W. Maps (op, rs, rt) to taken/neql. The top level contains only the handshake register and the optional counters.

## Test plan
- Reset release, then BEQ with rs=rt=0x1234_5678: out_valid after 1 edge, out_taken=1, out_neql=0. BNE with the same operands: out_taken=0.
- Sign boundaries with rs=0x8000_0000, 0x0000_0000, 0x7FFF_FFFF:
  - BLEZ → 1,1,0
  - BGTZ → 0,0,1
  - BLTZ → 1,0,0
  - BGEZ → 0,1,1
- Back-pressure: out_ready=0 for 3 cycles while in_valid stays high. Expect in_ready=0 and output stable. On out_ready=1, the next op is accepted the same cycle and streams 1/cycle.
- flush while out_valid=1, out_ready=0: out_valid=0 next edge, input not accepted that cycle, stat_resolved unchanged.
- Async resetn pulse between edges while out_valid=1: out_valid/out_taken drop immediately, and counters read 0.
- Stats build with CNT_W=4: 20 taken handshakes → stat_taken=15 and stat_resolved=15, both saturated. Non-stats build: both read 0.

Source files
------------

// File: rtl/branch_cond_pkg.sv
// Shared definitions for the branch-condition unit: condition opcode encoding.
package branch_cond_pkg;

    localparam int BR_OP_W = 3;

    typedef enum logic [BR_OP_W-1:0] {
        BR_BEQ    = 3'b000,
        BR_BNE    = 3'b001,
        BR_BLEZ   = 3'b010,
        BR_BGTZ   = 3'b011,
        BR_BLTZ   = 3'b100,
        BR_BGEZ   = 3'b101,
        BR_ALWAYS = 3'b110,
        BR_NEVER  = 3'b111
    } br_op_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational MIPS branch-condition evaluator: (op, rs, rt) -> taken/neql.
// Signed tests are built from the sign bit and a zero-detect only.
module branch_cond_eval
    import branch_cond_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [BR_OP_W-1:0] op_i,
    input  logic [DATA_W-1:0]  rs_i,
    input  logic [DATA_W-1:0]  rt_i,
    output logic               taken_o,
    output logic               neql_o
);

    logic rs_zero_s;
    logic rs_neg_s;

    assign rs_zero_s = (rs_i == {DATA_W{1'b0}});
    assign rs_neg_s  = rs_i[DATA_W-1];
    assign neql_o    = (rs_i != rt_i);

    // Condition select
    always_comb begin
        taken_o = 1'b0;
        case (br_op_e'(op_i))
            BR_BEQ:    taken_o = !neql_o;
            BR_BNE:    taken_o = neql_o;
            BR_BLEZ:   taken_o = rs_neg_s || rs_zero_s;
            BR_BGTZ:   taken_o = !rs_neg_s && !rs_zero_s;
            BR_BLTZ:   taken_o = rs_neg_s;
            BR_BGEZ:   taken_o = !rs_neg_s;
            BR_ALWAYS: taken_o = 1'b1;
            BR_NEVER:  taken_o = 1'b0;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch resolver with a single-entry valid/ready output stage.
// Optional saturating statistics counters: define BRANCH_COND_STATS_EN.
module branch_cond_unit
    import branch_cond_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BR_OP_W-1:0] in_op,
    input  logic [DATA_W-1:0]  in_rs,
    input  logic [DATA_W-1:0]  in_rt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_taken,
    output logic               out_neql,
    output logic [CNT_W-1:0]   stat_resolved,
    output logic [CNT_W-1:0]   stat_taken
);

    logic eval_taken_s;
    logic eval_neql_s;
    logic accept_s;
    logic deliver_s;
    logic out_valid_q, out_valid_d;
    logic out_taken_q, out_taken_d;
    logic out_neql_q,  out_neql_d;

    branch_cond_eval #(.DATA_W(DATA_W)) u_eval (
        .op_i    (in_op),
        .rs_i    (in_rs),
        .rt_i    (in_rt),
        .taken_o (eval_taken_s),
        .neql_o  (eval_neql_s)
    );

    assign in_ready  = !flush && (!out_valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    // A result discarded by flush is not a delivery.
    assign deliver_s = out_valid_q && out_ready && !flush;

    // Output-stage next state; data registers only load on accept
    always_comb begin
        out_valid_d = out_valid_q;
        out_taken_d = out_taken_q;
        out_neql_d  = out_neql_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_taken_d = eval_taken_s;
            out_neql_d  = eval_neql_s;
        end else if (deliver_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output-stage registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_taken_q <= 1'b0;
            out_neql_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_taken_q <= out_taken_d;
            out_neql_q  <= out_neql_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_taken = out_taken_q;
    assign out_neql  = out_neql_q;

`ifdef BRANCH_COND_STATS_EN
    logic [CNT_W-1:0] resolved_q;
    logic [CNT_W-1:0] taken_cnt_q;

    // Saturating delivery counters, cleared only by resetn
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resolved_q  <= {CNT_W{1'b0}};
            taken_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (deliver_s && (resolved_q != {CNT_W{1'b1}})) begin
                resolved_q <= resolved_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (deliver_s && out_taken_q && (taken_cnt_q != {CNT_W{1'b1}})) begin
                taken_cnt_q <= taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stat_resolved = resolved_q;
    assign stat_taken    = taken_cnt_q;
`else
    assign stat_resolved = {CNT_W{1'b0}};
    assign stat_taken    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed scoreboard bench for branch_cond_unit; checks stats against a model
// when BRANCH_COND_STATS_EN is defined, otherwise expects them tied to zero.
module tb_branch_cond_unit;
    import branch_cond_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_rs;
    logic [DATA_W-1:0] in_rt;
    logic              out_valid;
    logic              out_ready;
    logic              out_taken;
    logic              out_neql;
    logic [CNT_W-1:0]  stat_resolved;
    logic [CNT_W-1:0]  stat_taken;

    int checks   = 0;
    int failures = 0;

    logic       mv;
    logic [1:0] sbq[$];
    logic [CNT_W-1:0] m_res;
    logic [CNT_W-1:0] m_tak;

    branch_cond_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_neql(out_neql),
        .stat_resolved(stat_resolved), .stat_taken(stat_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {taken, neql}, written with signed arithmetic compares
    function automatic logic [1:0] ref_eval(input logic [2:0] op,
                                            input logic [DATA_W-1:0] rs,
                                            input logic [DATA_W-1:0] rt);
        logic t;
        case (op)
            3'd0:    t = (rs == rt);
            3'd1:    t = (rs != rt);
            3'd2:    t = ($signed(rs) <= 0);
            3'd3:    t = ($signed(rs) > 0);
            3'd4:    t = ($signed(rs) < 0);
            3'd5:    t = ($signed(rs) >= 0);
            3'd6:    t = 1'b1;
            default: t = 1'b0;
        endcase
        return {t, (rs != rt)};
    endfunction

    task automatic chk_stats(input string tag);
`ifdef BRANCH_COND_STATS_EN
        chk({tag, ":stat_resolved"}, 32'(stat_resolved), 32'(m_res));
        chk({tag, ":stat_taken"},    32'(stat_taken),    32'(m_tak));
`else
        chk({tag, ":stat_resolved"}, 32'(stat_resolved), 32'd0);
        chk({tag, ":stat_taken"},    32'(stat_taken),    32'd0);
`endif
    endtask

    // One clock cycle: drive, check combinational/held outputs, advance model, check after edge
    task automatic cyc(input logic v, input logic [2:0] op, input logic [DATA_W-1:0] rs,
                       input logic [DATA_W-1:0] rt, input logic ordy, input logic fl,
                       input string tag);
        logic acc;
        logic hs;
        logic [1:0] e;
        in_valid  = v;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(!fl && (!mv || ordy)));
        hs  = mv && ordy;
        acc = v && !fl && (!mv || ordy);
        if (mv) begin
            if (sbq.size() == 0) begin
                chk({tag, ":scoreboard"}, 32'd0, 32'd1);
            end else begin
                e = sbq[0];
                chk({tag, ":out_taken"}, 32'(out_taken), 32'(e[1]));
                chk({tag, ":out_neql"},  32'(out_neql),  32'(e[0]));
                if (fl || hs) begin
                    void'(sbq.pop_front());
                end
                if (hs && !fl) begin
                    if (m_res != {CNT_W{1'b1}}) m_res = m_res + 1'b1;
                    if (e[1] && (m_tak != {CNT_W{1'b1}})) m_tak = m_tak + 1'b1;
                end
            end
        end
        if (acc) sbq.push_back(ref_eval(op, rs, rt));
        mv = fl ? 1'b0 : (acc ? 1'b1 : (hs ? 1'b0 : mv));
        @(posedge clk);
        #2;
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(mv));
        chk_stats(tag);
    endtask

    logic [DATA_W-1:0] sign_vals [3];

    initial begin
        sign_vals[0] = 32'h8000_0000;
        sign_vals[1] = 32'h0000_0000;
        sign_vals[2] = 32'h7FFF_FFFF;
        mv = 1'b0;
        m_res = '0;
        m_tak = '0;
        resetn = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_op = 3'd0;
        in_rs = '0;
        in_rt = '0;
        out_ready = 1'b0;
        #3;
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        chk("reset:out_taken", 32'(out_taken), 32'd0);
        chk("reset:out_neql",  32'(out_neql),  32'd0);
        chk_stats("reset");
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // Equality pair
        cyc(1'b1, BR_BEQ, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, "beq");
        cyc(1'b1, BR_BNE, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, "bne");
        cyc(1'b1, BR_BNE, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b0, "bne_diff");

        // Sign boundaries, streamed back to back
        for (int op = 2; op <= 5; op++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(1'b1, 3'(op), sign_vals[k], 32'h0000_0001, 1'b1, 1'b0, $sformatf("sign_op%0d_v%0d", op, k));
            end
        end
        cyc(1'b0, BR_BEQ, '0, '0, 1'b1, 1'b0, "drain1");

        // Back-pressure with in_valid held, then streaming release
        cyc(1'b1, BR_BEQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, "bp_load");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, BR_BNE, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, $sformatf("bp_hold%0d", i));
        end
        cyc(1'b1, BR_BNE,  32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, "bp_release");
        cyc(1'b1, BR_BGEZ, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "bp_stream1");
        cyc(1'b1, BR_BLTZ, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "bp_stream2");
        cyc(1'b0, BR_BEQ, '0, '0, 1'b1, 1'b0, "drain2");

        // Flush with a stalled result, and flush racing a drain + new input
        cyc(1'b1, BR_ALWAYS, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, "fl_load");
        cyc(1'b1, BR_NEVER,  32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, "fl_stalled");
        cyc(1'b0, BR_BEQ, '0, '0, 1'b1, 1'b0, "fl_after");
        cyc(1'b1, BR_ALWAYS, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, "fl2_load");
        cyc(1'b1, BR_ALWAYS, 32'h0000_0007, 32'h0000_0008, 1'b1, 1'b1, "fl2_race");
        cyc(1'b0, BR_BEQ, '0, '0, 1'b1, 1'b0, "fl2_after");

        // Asynchronous reset pulse between edges while a taken result is held
        cyc(1'b1, BR_ALWAYS, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, "ar_load");
        #1;
        resetn = 1'b0;
        #1;
        chk("ar:out_valid", 32'(out_valid), 32'd0);
        chk("ar:out_taken", 32'(out_taken), 32'd0);
        chk("ar:out_neql",  32'(out_neql),  32'd0);
        chk("ar:stat_resolved", 32'(stat_resolved), 32'd0);
        chk("ar:stat_taken",    32'(stat_taken),    32'd0);
        mv = 1'b0;
        sbq.delete();
        m_res = '0;
        m_tak = '0;
        resetn = 1'b1;

        // Saturation: 21 taken results streamed and delivered
        for (int i = 0; i < 21; i++) begin
            cyc(1'b1, BR_ALWAYS, 32'(i), 32'(i), 1'b1, 1'b0, $sformatf("sat%0d", i));
        end
        cyc(1'b0, BR_BEQ, '0, '0, 1'b1, 1'b0, "sat_drain");
`ifdef BRANCH_COND_STATS_EN
        chk("sat:stat_resolved", 32'(stat_resolved), 32'h0000_000F);
        chk("sat:stat_taken",    32'(stat_taken),    32'h0000_000F);
`else
        chk("sat:stat_resolved", 32'(stat_resolved), 32'd0);
        chk("sat:stat_taken",    32'(stat_taken),    32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
